// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and adder-stage bundle for nibble_serial_adder_ctrl.
// The slave modport is the controller's view. The master modport is the environment's view.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial wide adder controller. It drives an external 4-bit adder one nibble per cycle, LSB first.
// The carry is chained through a register, and the assembled sum is presented over valid/ready.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    nibble_serial_adder_ctrl_if.slave bus,
    output logic                      busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef logic [NIBBLES-1:0][3:0] word_t;

    state_e           state_q, state_d;
    word_t            a_q, a_d;
    word_t            b_q, b_d;
    word_t            sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             accept;

    // Gating with rst keeps the handshakes quiet during the reset cycle itself.
    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_DONE) && !rst;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign busy          = (state_q != S_IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    // The adder sees zeros except while a pass is in flight.
    assign bus.add_a   = (state_q == S_RUN) ? a_q[idx_q] : 4'h0;
    assign bus.add_b   = (state_q == S_RUN) ? b_q[idx_q] : 4'h0;
    assign bus.add_cin = (state_q == S_RUN) ? carry_q    : 1'b0;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q] = bus.add_sum;
                carry_d      = bus.add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = bus.add_cout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, including the operand and sum words.
        // An abort mid-operation therefore leaves no partial result visible.
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end
endmodule
